// File: rtl/ram_arbiter_if.sv
// Request/response and RAM-side signals of the shared single-port RAM arbiter.
// Handshake: a requester holds req with stable fields until its one-cycle
// ack/valid pulse; a req still high in that pulse cycle is a new request.
interface ram_arbiter_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 4,
  parameter int PC_W   = 8
);
  logic              i_fetch_req;
  logic [PC_W-1:0]   i_fetch_pc;
  logic              o_fetch_valid;
  logic [DATA_W-1:0] o_fetch_instr;
  logic              o_fetch_err;

  logic              i_mem_req;
  logic              i_mem_we;
  logic [ADDR_W-1:0] i_mem_addr;
  logic [DATA_W-1:0] i_mem_wdata;
  logic              o_mem_ack;
  logic [DATA_W-1:0] o_mem_rdata;

  logic              o_busy;

  logic [ADDR_W-1:0] o_ramaddr;
  logic [1:0]        o_RW;
  logic [DATA_W-1:0] o_databus;
  logic [PC_W-1:0]   o_PC;
  logic [DATA_W-1:0] i_databus;
  logic [DATA_W-1:0] i_instrfetch;

  modport slave (
    input  i_fetch_req, i_fetch_pc, i_mem_req, i_mem_we, i_mem_addr, i_mem_wdata,
    input  i_databus, i_instrfetch,
    output o_fetch_valid, o_fetch_instr, o_fetch_err, o_mem_ack, o_mem_rdata,
    output o_busy, o_ramaddr, o_RW, o_databus, o_PC
  );

  modport master (
    output i_fetch_req, i_fetch_pc, i_mem_req, i_mem_we, i_mem_addr, i_mem_wdata,
    output i_databus, i_instrfetch,
    input  o_fetch_valid, o_fetch_instr, o_fetch_err, o_mem_ack, o_mem_rdata,
    input  o_busy, o_ramaddr, o_RW, o_databus, o_PC
  );
endinterface

// File: rtl/ram_arbiter.sv
// Shares one single-port RAM between instruction fetch and load/store, with a
// data-first policy bounded by a streak counter so fetch cannot starve.
module ram_arbiter #(
  parameter int DATA_W    = 32,
  parameter int ADDR_W    = 4,
  parameter int PC_W      = 8,
  parameter int RAM_DEPTH = 16,
  parameter int MAX_DATA  = 3
) (
  input  logic       clk,
  input  logic       rst_n,
  ram_arbiter_if.slave bus,
  output logic [2:0] dbg_state
);
  typedef enum logic [2:0] {IDLE, FETCH, LOAD, ST_SETUP, ST_WRITE} state_t;

  localparam int SW = $clog2(MAX_DATA + 1);
  localparam logic [SW-1:0] STREAK_MAX = SW'(MAX_DATA);
  localparam logic [PC_W:0] DEPTH_PC = RAM_DEPTH[PC_W:0];

  state_t            state_q, state_d;
  logic [SW-1:0]     streak_q, streak_d;
  logic [ADDR_W-1:0] ramaddr_q, ramaddr_d;
  logic [1:0]        rw_q, rw_d;
  logic [DATA_W-1:0] databus_q, databus_d;
  logic [PC_W-1:0]   pc_q, pc_d;
  logic              fetch_valid_q, fetch_valid_d;
  logic              fetch_err_q, fetch_err_d;
  logic [DATA_W-1:0] fetch_instr_q, fetch_instr_d;
  logic              mem_ack_q, mem_ack_d;
  logic [DATA_W-1:0] mem_rdata_q, mem_rdata_d;
  logic              data_win, fetch_win;

  // Data wins unless fetch is waiting and data has already had its full streak.
  assign data_win  = bus.i_mem_req && !(bus.i_fetch_req && streak_q == STREAK_MAX);
  assign fetch_win = bus.i_fetch_req && !data_win;

  always_comb begin
    state_d       = state_q;
    streak_d      = streak_q;
    ramaddr_d     = ramaddr_q;
    rw_d          = 2'b00;
    databus_d     = databus_q;
    pc_d          = pc_q;
    fetch_valid_d = 1'b0;
    fetch_err_d   = 1'b0;
    fetch_instr_d = fetch_instr_q;
    mem_ack_d     = 1'b0;
    mem_rdata_d   = mem_rdata_q;
    case (state_q)
      IDLE: begin
        databus_d = '0;
        if (data_win) begin
          if (streak_q != STREAK_MAX) streak_d = streak_q + SW'(1);
          ramaddr_d = bus.i_mem_addr;
          if (bus.i_mem_we) begin
            databus_d = bus.i_mem_wdata;
            state_d   = ST_SETUP;
          end else begin
            rw_d    = 2'b01;
            state_d = LOAD;
          end
        end else if (fetch_win) begin
          streak_d = '0;
          pc_d     = bus.i_fetch_pc;
          state_d  = FETCH;
        end
      end
      FETCH: begin
        fetch_valid_d = 1'b1;
        if ({1'b0, pc_q} >= DEPTH_PC) begin
          fetch_instr_d = '0;
          fetch_err_d   = 1'b1;
        end else begin
          fetch_instr_d = bus.i_instrfetch;
        end
        state_d = IDLE;
      end
      LOAD: begin
        mem_rdata_d = bus.i_databus;
        mem_ack_d   = 1'b1;
        state_d     = IDLE;
      end
      ST_SETUP: begin
        rw_d    = 2'b10;
        state_d = ST_WRITE;
      end
      // Address and data are held through the ack cycle after write enable drops.
      ST_WRITE: begin
        mem_ack_d = 1'b1;
        state_d   = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= IDLE;
      streak_q      <= '0;
      ramaddr_q     <= '0;
      rw_q          <= 2'b00;
      databus_q     <= '0;
      pc_q          <= '0;
      fetch_valid_q <= 1'b0;
      fetch_err_q   <= 1'b0;
      fetch_instr_q <= '0;
      mem_ack_q     <= 1'b0;
      mem_rdata_q   <= '0;
    end else begin
      state_q       <= state_d;
      streak_q      <= streak_d;
      ramaddr_q     <= ramaddr_d;
      rw_q          <= rw_d;
      databus_q     <= databus_d;
      pc_q          <= pc_d;
      fetch_valid_q <= fetch_valid_d;
      fetch_err_q   <= fetch_err_d;
      fetch_instr_q <= fetch_instr_d;
      mem_ack_q     <= mem_ack_d;
      mem_rdata_q   <= mem_rdata_d;
    end
  end

  assign bus.o_ramaddr     = ramaddr_q;
  assign bus.o_RW          = rw_q;
  assign bus.o_databus     = databus_q;
  assign bus.o_PC          = pc_q;
  assign bus.o_fetch_valid = fetch_valid_q;
  assign bus.o_fetch_err   = fetch_err_q;
  assign bus.o_fetch_instr = fetch_instr_q;
  assign bus.o_mem_ack     = mem_ack_q;
  assign bus.o_mem_rdata   = mem_rdata_q;
  assign bus.o_busy        = (state_q != IDLE);
  assign dbg_state         = state_q;
endmodule
